// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_pkg                                                                    |
// | Shared types and widths for the memory-access stage.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WAIT  = ST_WAIT,
    DRAIN = ST_DRAIN
  } mem_state_e;

  typedef struct packed {
    logic              op_store;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } mem_entry_t;

  // Stores complete with a zero result; loads forward the cache data.
  function automatic logic [DATA_W-1:0] mem_result(input logic op_store,
                                                   input logic [DATA_W-1:0] rdata);
    return op_store ? '0 : rdata;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_req_fifo.sv
// +----------------------------------------------------------------------------+
// | mem_req_fifo                                                               |
// | In-order request queue of mem_entry_t with flush and registered almost-full|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  mem_entry_t             push_entry,
  input  logic                   pop,
  output mem_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  mem_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // A full queue still accepts a push when the head leaves on the same edge.
    do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d = (count_d >= CNT_W'(DEPTH - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = full_q;

`ifndef SYNTHESIS
  a_push_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !flush && !do_pop && (count_q == CNT_W'(DEPTH))));
`endif

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                            |
// | Queues AGU addresses, issues them one at a time to the data cache and      |
// | returns tagged results. Optional MEM_PERF_CNT_EN adds perf counters.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze_back,
  input  logic              valid_Addr_agu,
  input  logic [ADDR_W-1:0] Addr_agu,
  input  logic [TAG_W-1:0]  tag_ROB_Result_agu,
  input  logic              op_store_agu,
  input  logic [DATA_W-1:0] data_store_agu,
  output logic              full_mem,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic              valid_Result_mem,
  output logic [DATA_W-1:0] Result_mem,
  output logic [TAG_W-1:0]  tag_ROB_Result_mem
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [15:0]       cnt_load,
  output logic [15:0]       cnt_store,
  output logic [15:0]       cnt_stall
`endif
);

  mem_state_e              state_q, state_d;
  logic                    op_q, op_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic                    skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0]       skid_res_q, skid_res_d;
  logic [TAG_W-1:0]        skid_tag_q, skid_tag_d;
  logic                    out_vld_q, out_vld_d;
  logic [DATA_W-1:0]       out_res_q, out_res_d;
  logic [TAG_W-1:0]        out_tag_q, out_tag_d;

  mem_entry_t              push_entry, head;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    hs, resp_take;
  logic [DATA_W-1:0]       result;

  assign push_entry = '{op_store: op_store_agu, addr: Addr_agu,
                        data: data_store_agu, tag: tag_ROB_Result_agu};

  mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push        (valid_Addr_agu),
    .push_entry  (push_entry),
    .pop         (hs),
    .head        (head),
    .count       (fifo_count),
    .almost_full (full_mem)
  );

  always_comb begin
    req_valid = (state_q == IDLE) && (fifo_count != '0) && !freeze_back && !skid_vld_q;
    hs        = req_valid && req_ready;
    resp_take = (state_q == WAIT) && resp_valid && !flush;
    result    = mem_result(op_q, resp_rdata);

    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = head.op_store;
          tag_d   = head.tag;
          // A request accepted under flush is still owed a response.
          state_d = flush ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (resp_valid)  state_d = IDLE;
        else if (flush)  state_d = DRAIN;
      end
      DRAIN: begin
        if (resp_valid)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    skid_vld_d = skid_vld_q;
    skid_res_d = skid_res_q;
    skid_tag_d = skid_tag_q;
    out_vld_d  = out_vld_q;
    out_res_d  = out_res_q;
    out_tag_d  = out_tag_q;
    if (flush) begin
      skid_vld_d = 1'b0;
      skid_res_d = '0;
      skid_tag_d = '0;
      out_vld_d  = 1'b0;
      out_res_d  = '0;
      out_tag_d  = '0;
    end else if (freeze_back) begin
      if (resp_take) begin
        skid_vld_d = 1'b1;
        skid_res_d = result;
        skid_tag_d = tag_q;
      end
    end else if (skid_vld_q) begin
      // Skid blocks issue, so no response can collide with its drain.
      skid_vld_d = 1'b0;
      out_vld_d  = 1'b1;
      out_res_d  = skid_res_q;
      out_tag_d  = skid_tag_q;
    end else if (resp_take) begin
      out_vld_d  = 1'b1;
      out_res_d  = result;
      out_tag_d  = tag_q;
    end else begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      tag_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_res_q <= '0;
      skid_tag_q <= '0;
      out_vld_q  <= 1'b0;
      out_res_q  <= '0;
      out_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      skid_vld_q <= skid_vld_d;
      skid_res_q <= skid_res_d;
      skid_tag_q <= skid_tag_d;
      out_vld_q  <= out_vld_d;
      out_res_q  <= out_res_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign req_we             = head.op_store;
  assign req_addr           = head.addr;
  assign req_wdata          = head.data;
  assign valid_Result_mem   = out_vld_q;
  assign Result_mem         = out_res_q;
  assign tag_ROB_Result_mem = out_tag_q;

`ifdef MEM_PERF_CNT_EN
  logic [15:0] cnt_load_q, cnt_load_d;
  logic [15:0] cnt_store_q, cnt_store_d;
  logic [15:0] cnt_stall_q, cnt_stall_d;

  always_comb begin
    cnt_load_d  = cnt_load_q;
    cnt_store_d = cnt_store_q;
    cnt_stall_d = cnt_stall_q;
    if (resp_take && !op_q && (cnt_load_q != 16'hFFFF))  cnt_load_d  = cnt_load_q + 16'd1;
    if (resp_take && op_q && (cnt_store_q != 16'hFFFF))  cnt_store_d = cnt_store_q + 16'd1;
    if (req_valid && !req_ready && (cnt_stall_q != 16'hFFFF)) cnt_stall_d = cnt_stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_load_q  <= '0;
      cnt_store_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      cnt_load_q  <= cnt_load_d;
      cnt_store_q <= cnt_store_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  assign cnt_load  = cnt_load_q;
  assign cnt_store = cnt_store_q;
  assign cnt_stall = cnt_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit                                                         |
// | Table vectors, directed corner sequences and a random run for the unit.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, freeze_back = 1'b0;
  logic        valid_Addr_agu = 1'b0, op_store_agu = 1'b0;
  logic [15:0] Addr_agu = '0, data_store_agu = '0;
  logic [4:0]  tag_ROB_Result_agu = '0;
  logic        req_ready = 1'b0, resp_valid = 1'b0;
  logic [15:0] resp_rdata = '0;
  logic        full_mem, req_valid, req_we, valid_Result_mem;
  logic [15:0] req_addr, req_wdata, Result_mem;
  logic [4:0]  tag_ROB_Result_mem;
`ifdef MEM_PERF_CNT_EN
  logic [15:0] cnt_load, cnt_store, cnt_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .freeze_back        (freeze_back),
    .valid_Addr_agu     (valid_Addr_agu),
    .Addr_agu           (Addr_agu),
    .tag_ROB_Result_agu (tag_ROB_Result_agu),
    .op_store_agu       (op_store_agu),
    .data_store_agu     (data_store_agu),
    .full_mem           (full_mem),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_we             (req_we),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_rdata         (resp_rdata),
    .valid_Result_mem   (valid_Result_mem),
    .Result_mem         (Result_mem),
    .tag_ROB_Result_mem (tag_ROB_Result_mem)
`ifdef MEM_PERF_CNT_EN
    ,
    .cnt_load           (cnt_load),
    .cnt_store          (cnt_store),
    .cnt_stall          (cnt_stall)
`endif
  );

  typedef struct {
    logic        v;   logic [15:0] a;  logic [4:0] t;  logic st;  logic [15:0] d;
    logic        rdy; logic rv;        logic [15:0] rd;
    logic        e_rv; logic e_we; logic [15:0] e_ra; logic [15:0] e_wd;
    logic        e_vr; logic [15:0] e_res; logic [4:0] e_tag; logic e_full;
  } vec_t;

  typedef struct {
    logic st; logic [15:0] a; logic [15:0] d; logic [4:0] t; logic [15:0] res;
  } req_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic v, input logic [15:0] a, input logic [4:0] t,
                              input logic st, input logic [15:0] d, input logic rdy,
                              input logic rv, input logic [15:0] rd, input logic e_rv,
                              input logic e_we, input logic [15:0] e_ra, input logic [15:0] e_wd,
                              input logic e_vr, input logic [15:0] e_res, input logic [4:0] e_tag,
                              input logic e_full);
    vec_t r;
    r.v = v; r.a = a; r.t = t; r.st = st; r.d = d; r.rdy = rdy; r.rv = rv; r.rd = rd;
    r.e_rv = e_rv; r.e_we = e_we; r.e_ra = e_ra; r.e_wd = e_wd;
    r.e_vr = e_vr; r.e_res = e_res; r.e_tag = e_tag; r.e_full = e_full;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the falling edge, then settle.
  task automatic cyc(input logic v, input logic [15:0] a, input logic [4:0] t, input logic st,
                     input logic [15:0] d, input logic rdy, input logic rv, input logic [15:0] rd,
                     input logic frz, input logic fl);
    @(negedge clk);
    valid_Addr_agu = v; Addr_agu = a; tag_ROB_Result_agu = t; op_store_agu = st;
    data_store_agu = d; req_ready = rdy; resp_valid = rv; resp_rdata = rd;
    freeze_back = frz; flush = fl;
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 16'h0, 5'd0, 1'b0, 16'h0, rdy, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  req_t        iss_q[$];
  req_t        cmp_q[$];
  logic [15:0] ref_mem   [logic [15:0]];
  logic [15:0] cache_mem [logic [15:0]];

  initial begin
    // ---------------- reset values ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vr", valid_Result_mem, 1'b0);
    chk("rst_res", Result_mem, 16'h0);
    chk("rst_tag", tag_ROB_Result_mem, 5'd0);
    chk("rst_full", full_mem, 1'b0);
    chk("rst_req_valid", req_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1);

    // ---------------- table: load, store, back-to-back with full ----------------
    //          v  addr     t  st data     rdy rv rdata     erv ewe era      ewd      evr eres     etag efull
    vecs.push_back(mk(1, 'h0040, 3, 0, 'h0000, 1, 0, 'h0000,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  1, 0, 'h0040, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 1, 'hBEEF,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  0, 0, 'h0000, 'h0000,  1, 'hBEEF, 3, 0));
    vecs.push_back(mk(1, 'h0010, 7, 1, 'h1234, 1, 0, 'h0000,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  1, 1, 'h0010, 'h1234,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 1, 'hDEAD,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  0, 0, 'h0000, 'h0000,  1, 'h0000, 7, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(1, 'h0100, 0, 0, 'h0000, 0, 0, 'h0000,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(1, 'h0101, 1, 0, 'h0000, 0, 0, 'h0000,  1, 0, 'h0100, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(1, 'h0102, 2, 0, 'h0000, 0, 0, 'h0000,  1, 0, 'h0100, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(1, 'h0103, 3, 0, 'h0000, 0, 0, 'h0000,  1, 0, 'h0100, 'h0000,  0, 'h0000, 0, 1));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 0, 0, 'h0000,  1, 0, 'h0100, 'h0000,  0, 'h0000, 0, 1));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  1, 0, 'h0100, 'h0000,  0, 'h0000, 0, 1));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 1, 'hA000,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 1));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  1, 0, 'h0101, 'h0000,  1, 'hA000, 0, 1));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 1, 'hA001,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  1, 0, 'h0102, 'h0000,  1, 'hA001, 1, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 1, 'hA002,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  1, 0, 'h0103, 'h0000,  1, 'hA002, 2, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 1, 'hA003,  0, 0, 'h0000, 'h0000,  0, 'h0000, 0, 0));
    vecs.push_back(mk(0, 'h0000, 0, 0, 'h0000, 1, 0, 'h0000,  0, 0, 'h0000, 'h0000,  1, 'hA003, 3, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].v, vecs[i].a, vecs[i].t, vecs[i].st, vecs[i].d, vecs[i].rdy,
          vecs[i].rv, vecs[i].rd, 1'b0, 1'b0);
      chk($sformatf("vec%0d_req_valid", i), req_valid, vecs[i].e_rv);
      chk($sformatf("vec%0d_vr", i), valid_Result_mem, vecs[i].e_vr);
      chk($sformatf("vec%0d_full", i), full_mem, vecs[i].e_full);
      if (vecs[i].e_rv) begin
        chk($sformatf("vec%0d_req_we", i), req_we, vecs[i].e_we);
        chk($sformatf("vec%0d_req_addr", i), req_addr, vecs[i].e_ra);
        if (vecs[i].e_we) chk($sformatf("vec%0d_req_wdata", i), req_wdata, vecs[i].e_wd);
      end
      if (vecs[i].e_vr) begin
        chk($sformatf("vec%0d_res", i), Result_mem, vecs[i].e_res);
        chk($sformatf("vec%0d_tag", i), tag_ROB_Result_mem, vecs[i].e_tag);
      end
    end

    // ---------------- flush while waiting, response two cycles later ----------------
    cyc(1'b1, 16'h0300, 5'd9, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("fl_vr0", valid_Result_mem, 1'b0);
    idle(1'b1);
    chk("fl_issue", req_valid, 1'b1);
    chk("fl_issue_addr", req_addr, 16'h0300);
    cyc(1'b1, 16'h0301, 5'd10, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("fl_wait_rv", req_valid, 1'b0);
    cyc(1'b1, 16'h0302, 5'd13, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("fl_drain_rv", req_valid, 1'b0);
    chk("fl_drain_vr", valid_Result_mem, 1'b0);
    cyc(1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
    chk("fl_drain_rv2", req_valid, 1'b0);
    idle(1'b1);
    chk("fl_discard_vr", valid_Result_mem, 1'b0);
    chk("fl_resume_rv", req_valid, 1'b1);
    chk("fl_resume_addr", req_addr, 16'h0302);
    cyc(1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h8888, 1'b0, 1'b0);
    idle(1'b1);
    chk("fl_done_vr", valid_Result_mem, 1'b1);
    chk("fl_done_res", Result_mem, 16'h8888);
    chk("fl_done_tag", tag_ROB_Result_mem, 5'd13);
    chk("fl_empty", req_valid, 1'b0);

    // ---------------- freeze while a response arrives ----------------
    cyc(1'b1, 16'h0200, 5'd5, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0201, 5'd6, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("fz_issue_addr", req_addr, 16'h0200);
    cyc(1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0);
    chk("fz_vr_a", valid_Result_mem, 1'b0);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
      chk($sformatf("fz_hold_vr%0d", k), valid_Result_mem, 1'b0);
      chk($sformatf("fz_no_issue%0d", k), req_valid, 1'b0);
    end
    idle(1'b1);
    chk("fz_rel_vr", valid_Result_mem, 1'b0);
    chk("fz_skid_blocks", req_valid, 1'b0);
    idle(1'b1);
    chk("fz_out_vr", valid_Result_mem, 1'b1);
    chk("fz_out_res", Result_mem, 16'h5555);
    chk("fz_out_tag", tag_ROB_Result_mem, 5'd5);
    chk("fz_resume", req_valid, 1'b1);
    chk("fz_resume_addr", req_addr, 16'h0201);
    cyc(1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h6666, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("fz2_vr", valid_Result_mem, 1'b1);
    chk("fz2_res", Result_mem, 16'h6666);
    idle(1'b1);
    chk("fz2_held_vr", valid_Result_mem, 1'b1);
    chk("fz2_held_tag", tag_ROB_Result_mem, 5'd6);
    idle(1'b1);
    chk("fz2_pulse_end", valid_Result_mem, 1'b0);

    // ---------------- reset mid-transaction ----------------
    cyc(1'b1, 16'h0400, 5'd11, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0401, 5'd12, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0402, 5'd14, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0403, 5'd15, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(1'b1);
    chk("rs_full_before", full_mem, 1'b1);
    chk("rs_tag_before", tag_ROB_Result_mem, 5'd6);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rs_full", full_mem, 1'b0);
    chk("rs_req_valid", req_valid, 1'b0);
    chk("rs_vr", valid_Result_mem, 1'b0);
    chk("rs_res", Result_mem, 16'h0);
    chk("rs_tag", tag_ROB_Result_mem, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 16'h0040, 5'd3, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    idle(1'b1);
    chk("rs_new_rv", req_valid, 1'b1);
    chk("rs_new_addr", req_addr, 16'h0040);
    cyc(1'b0, 16'h0, 5'd0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    idle(1'b1);
    chk("rs_new_vr", valid_Result_mem, 1'b1);
    chk("rs_new_res", Result_mem, 16'h1111);
    chk("rs_new_tag", tag_ROB_Result_mem, 5'd3);
    idle(1'b1);

    // ---------------- random traffic against a sequential-execution model ----------------
    begin
      logic        busy = 1'b0;
      int          wl = 0;
      logic [15:0] prd = '0;
      logic        prev_frz = 1'b0;
      logic        pv = 1'b0;
      logic [15:0] pres = '0;
      logic [4:0]  ptag = '0;
      int          seq = 0;
      for (int c = 0; c < 3000; c++) begin
        if (c >= 800 && cmp_q.size() == 0 && !busy) break;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_rdata = 16'($urandom);
        if (busy) begin
          if (wl == 0) begin
            resp_valid = 1'b1;
            resp_rdata = prd;
            busy = 1'b0;
          end else wl--;
        end
        valid_Addr_agu = 1'b0;
        if (c < 800 && !full_mem && ($urandom_range(1, 0) == 1)) begin
          req_t e;
          e.st = 1'($urandom_range(1, 0));
          e.a  = 16'($urandom_range(15, 0));
          e.d  = 16'($urandom);
          e.t  = 5'(seq);
          seq++;
          if (e.st) begin
            e.res = 16'h0;
            ref_mem[e.a] = e.d;
          end else begin
            e.res = ref_mem.exists(e.a) ? ref_mem[e.a] : (e.a ^ 16'h5A5A);
          end
          iss_q.push_back(e);
          cmp_q.push_back(e);
          valid_Addr_agu = 1'b1; Addr_agu = e.a; data_store_agu = e.d;
          tag_ROB_Result_agu = e.t; op_store_agu = e.st;
        end
        req_ready   = ($urandom_range(3, 0) != 0);
        freeze_back = ($urandom_range(4, 0) == 0);
        #1;
        if (prev_frz) begin
          chk("rnd_hold_vr", valid_Result_mem, pv);
          chk("rnd_hold_res", Result_mem, pres);
          chk("rnd_hold_tag", tag_ROB_Result_mem, ptag);
        end else if (valid_Result_mem) begin
          if (cmp_q.size() == 0) chk("rnd_spurious", 1'b1, 1'b0);
          else begin
            req_t x;
            x = cmp_q.pop_front();
            chk("rnd_res", Result_mem, x.res);
            chk("rnd_tag", tag_ROB_Result_mem, x.t);
          end
        end
        if (freeze_back) chk("rnd_frz_gate", req_valid, 1'b0);
        if (req_valid && req_ready) begin
          chk("rnd_single_outstanding", busy, 1'b0);
          if (iss_q.size() == 0) chk("rnd_issue_empty", 1'b1, 1'b0);
          else begin
            req_t x;
            x = iss_q.pop_front();
            chk("rnd_req_we", req_we, x.st);
            chk("rnd_req_addr", req_addr, x.a);
            if (x.st) chk("rnd_req_wdata", req_wdata, x.d);
          end
          if (req_we) begin
            cache_mem[req_addr] = req_wdata;
            prd = 16'($urandom);
          end else begin
            prd = cache_mem.exists(req_addr) ? cache_mem[req_addr] : (req_addr ^ 16'h5A5A);
          end
          busy = 1'b1;
          wl = $urandom_range(2, 0);
        end
        prev_frz = freeze_back;
        pv = valid_Result_mem; pres = Result_mem; ptag = tag_ROB_Result_mem;
      end
      chk("rnd_leftover", 16'(cmp_q.size()), 16'h0);
    end
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
